timeout_monitor: RTL and testbench

Multi-channel, parametrised watchdog that generalises the single-shot start-to-timeout counter used around kernel launches. Each channel is armed with a runtime timeout value, and can be kicked (reloaded), stopped, or left to expire. Each channel supports one-shot or auto-reload (periodic) mode, a sticky expiry flag, and a counter readback port. It sits beside the merger-tree kernel control logic and flags hung channels to the host-visible status registers.

---
 rtl/timeout_monitor_pkg.sv | 11 +
 rtl/timeout_monitor_ch.sv | 83 ++++++++
 rtl/timeout_monitor.sv | 72 +++++++
 tb/tb_timeout_monitor.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timeout_monitor_pkg.sv
// Shared constants for the multi-channel watchdog: FSM encodings and default widths.
package timeout_monitor_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_CNT_W = 32;

endpackage

// File: rtl/timeout_monitor_ch.sv
// One watchdog channel: countdown FSM with period latch, expiry pulse and sticky flag.
module timeout_monitor_ch
    import timeout_monitor_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [CNT_W-1:0] cfg_timeout,
    input  logic             arm,
    input  logic             kick,
    input  logic             stop,
    input  logic             clr,
    output logic             time_out,
    output logic             expired,
    output logic             busy,
    output logic [CNT_W-1:0] cnt
);

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] period_reg, period_next;
    logic             time_out_reg, pulse_next;
    logic             expired_reg, expired_next;
    logic [CNT_W-1:0] cfg_period;

    // A zero timeout would never expire from RUN, so it is promoted to one cycle.
    assign cfg_period = (cfg_timeout == '0) ? CNT_W'(1) : cfg_timeout;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        period_next = period_reg;
        pulse_next  = 1'b0;
        if (stop) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else if (arm) begin
            period_next = cfg_period;
            cnt_next    = cfg_period;
            state_next  = ST_RUN;
        end else if (kick && state_reg == ST_RUN) begin
            cnt_next = period_reg;
        end else if (state_reg == ST_RUN) begin
            if (cnt_reg == CNT_W'(1)) begin
                pulse_next = 1'b1;
                if (AUTO_RELOAD != 0) begin
                    cnt_next = period_reg;
                end else begin
                    cnt_next   = '0;
                    state_next = ST_DONE;
                end
            end else begin
                cnt_next = cnt_reg - CNT_W'(1);
            end
        end
        // A fresh expiry wins over a simultaneous clear.
        expired_next = pulse_next | (expired_reg & ~clr);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            period_reg   <= '0;
            time_out_reg <= 1'b0;
            expired_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            period_reg   <= period_next;
            time_out_reg <= pulse_next;
            expired_reg  <= expired_next;
        end
    end

    assign time_out = time_out_reg;
    assign expired  = expired_reg;
    assign busy     = (state_reg == ST_RUN);
    assign cnt      = cnt_reg;

endmodule

// File: rtl/timeout_monitor.sv
// Multi-channel watchdog: N_CH independent channels plus registered OR flag and count readback.
module timeout_monitor
    import timeout_monitor_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int AUTO_RELOAD = 0,
    parameter int SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [CNT_W-1:0] cfg_timeout,
    input  logic [N_CH-1:0]  arm,
    input  logic [N_CH-1:0]  kick,
    input  logic [N_CH-1:0]  stop,
    input  logic [N_CH-1:0]  clr,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [N_CH-1:0]  time_out,
    output logic [N_CH-1:0]  expired,
    output logic [N_CH-1:0]  busy,
    output logic             any_expired,
    output logic [CNT_W-1:0] rd_cnt
);

    logic [CNT_W-1:0] cnt_arr [N_CH];
    logic [CNT_W-1:0] rd_mux;
    logic             any_expired_reg;
    logic [CNT_W-1:0] rd_cnt_reg;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            timeout_monitor_ch #(
                .CNT_W       (CNT_W),
                .AUTO_RELOAD (AUTO_RELOAD)
            ) u_ch (
                .aclk        (aclk),
                .areset      (areset),
                .cfg_timeout (cfg_timeout),
                .arm         (arm[gi]),
                .kick        (kick[gi]),
                .stop        (stop[gi]),
                .clr         (clr[gi]),
                .time_out    (time_out[gi]),
                .expired     (expired[gi]),
                .busy        (busy[gi]),
                .cnt         (cnt_arr[gi])
            );
        end
    endgenerate

    // Out-of-range selects fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_sel == SEL_W'(i)) rd_mux = cnt_arr[i];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            any_expired_reg <= 1'b0;
            rd_cnt_reg      <= '0;
        end else begin
            any_expired_reg <= |expired;
            rd_cnt_reg      <= rd_mux;
        end
    end

    assign any_expired = any_expired_reg;
    assign rd_cnt      = rd_cnt_reg;

endmodule

// File: tb/tb_timeout_monitor.sv
// Bench for timeout_monitor: one-shot and periodic instances against a deadline-based model.
module tb_timeout_monitor;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] cfg_timeout = '0;
    logic [3:0]  arm = '0, kick = '0, stop = '0, clr = '0;
    logic [2:0]  rd_sel = '0;

    logic [3:0]  to0, ex0, bz0, to1, ex1, bz1;
    logic        any0, any1;
    logic [31:0] rd0, rd1;

    always #5 aclk = ~aclk;

    timeout_monitor #(.N_CH(4), .CNT_W(32), .AUTO_RELOAD(0), .SEL_W(3)) dut0 (
        .aclk(aclk), .areset(areset), .cfg_timeout(cfg_timeout), .arm(arm), .kick(kick),
        .stop(stop), .clr(clr), .rd_sel(rd_sel), .time_out(to0), .expired(ex0), .busy(bz0),
        .any_expired(any0), .rd_cnt(rd0));

    timeout_monitor #(.N_CH(4), .CNT_W(32), .AUTO_RELOAD(1), .SEL_W(3)) dut1 (
        .aclk(aclk), .areset(areset), .cfg_timeout(cfg_timeout), .arm(arm), .kick(kick),
        .stop(stop), .clr(clr), .rd_sel(rd_sel), .time_out(to1), .expired(ex1), .busy(bz1),
        .any_expired(any1), .rd_cnt(rd1));

    // Model: each running channel holds the absolute edge number of its next expiry.
    int e = 0;
    int dl [2][4];
    int per_m [2][4];
    bit run_m [2][4];
    bit ex_m [2][4];
    bit to_m [2][4];
    bit any_m [2];
    int rd_m [2];

    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  arm, kick, stop, clr;
        logic [31:0] cfg;
        logic [3:0]  to, ex, bz;
    } vec_t;
    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, e);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            any_m[d] = 0;
            rd_m[d] = 0;
            for (int c = 0; c < 4; c++) begin
                dl[d][c] = 0; per_m[d][c] = 0; run_m[d][c] = 0; ex_m[d][c] = 0; to_m[d][c] = 0;
            end
        end
    endtask

    function automatic logic [3:0] pack_m(input int d, input int which);
        logic [3:0] v;
        for (int c = 0; c < 4; c++)
            v[c] = (which == 0) ? to_m[d][c] : (which == 1) ? ex_m[d][c] : run_m[d][c];
        return v;
    endfunction

    task automatic check_all();
        chk("d0.time_out", 32'(to0), 32'(pack_m(0, 0)));
        chk("d0.expired", 32'(ex0), 32'(pack_m(0, 1)));
        chk("d0.busy", 32'(bz0), 32'(pack_m(0, 2)));
        chk("d0.any_expired", 32'(any0), 32'(any_m[0]));
        chk("d0.rd_cnt", rd0, 32'(rd_m[0]));
        chk("d1.time_out", 32'(to1), 32'(pack_m(1, 0)));
        chk("d1.expired", 32'(ex1), 32'(pack_m(1, 1)));
        chk("d1.busy", 32'(bz1), 32'(pack_m(1, 2)));
        chk("d1.any_expired", 32'(any1), 32'(any_m[1]));
        chk("d1.rd_cnt", rd1, 32'(rd_m[1]));
    endtask

    task automatic step();
        int  rd_new [2];
        bit  any_new [2];
        @(posedge aclk);
        for (int d = 0; d < 2; d++) begin
            any_new[d] = ex_m[d][0] | ex_m[d][1] | ex_m[d][2] | ex_m[d][3];
            rd_new[d] = (rd_sel < 4 && run_m[d][rd_sel]) ? dl[d][rd_sel] - e : 0;
        end
        e++;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                to_m[d][c] = 0;
                if (stop[c]) begin
                    run_m[d][c] = 0;
                end else if (arm[c]) begin
                    per_m[d][c] = (cfg_timeout == 0) ? 1 : int'(cfg_timeout);
                    dl[d][c] = e + per_m[d][c];
                    run_m[d][c] = 1;
                end else if (kick[c] && run_m[d][c]) begin
                    dl[d][c] = e + per_m[d][c];
                end else if (run_m[d][c] && dl[d][c] == e) begin
                    to_m[d][c] = 1;
                    if (d == 1) dl[d][c] = e + per_m[d][c];
                    else run_m[d][c] = 0;
                end
                if (to_m[d][c]) ex_m[d][c] = 1;
                else if (clr[c]) ex_m[d][c] = 0;
            end
            any_m[d] = any_new[d];
            rd_m[d] = rd_new[d];
        end
        #1;
        check_all();
        arm = '0; kick = '0; stop = '0; clr = '0;
    endtask

    function automatic vec_t mk(input logic [3:0] a, k, s, cl, input logic [31:0] cf,
                                input logic [3:0] t, x, b);
        vec_t v;
        v.arm = a; v.kick = k; v.stop = s; v.clr = cl; v.cfg = cf; v.to = t; v.ex = x; v.bz = b;
        return v;
    endfunction

    initial begin
        int pulses;
        int first_edge;
        int arm_edge;

        tbl[0]  = mk(4'b0001, 0, 0, 0, 2, 4'b0000, 4'b0000, 4'b0001);
        tbl[1]  = mk(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0001);
        tbl[2]  = mk(0, 0, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000);
        tbl[3]  = mk(0, 0, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000);
        tbl[4]  = mk(0, 0, 0, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[5]  = mk(4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0010);
        tbl[6]  = mk(0, 0, 0, 0, 0, 4'b0010, 4'b0010, 4'b0000);
        tbl[7]  = mk(4'b0100, 0, 0, 4'b0010, 3, 4'b0000, 4'b0000, 4'b0100);
        tbl[8]  = mk(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0100);
        tbl[9]  = mk(0, 4'b0100, 0, 0, 0, 4'b0000, 4'b0000, 4'b0100);
        tbl[10] = mk(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0100);
        tbl[11] = mk(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0100);
        tbl[12] = mk(0, 0, 4'b0100, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[13] = mk(0, 4'b0100, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[14] = mk(4'b0001, 0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0001);
        tbl[15] = mk(0, 0, 0, 4'b0001, 0, 4'b0001, 4'b0001, 4'b0000);
        tbl[16] = mk(0, 0, 0, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[17] = mk(4'b0001, 0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0001);
        tbl[18] = mk(0, 4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 4'b0001);
        tbl[19] = mk(0, 0, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000);
        tbl[20] = mk(0, 0, 0, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000);

        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        check_all();
        @(negedge aclk);
        areset = 1'b0;

        // Directed table on the one-shot instance.
        for (int i = 0; i < 21; i++) begin
            arm = tbl[i].arm; kick = tbl[i].kick; stop = tbl[i].stop; clr = tbl[i].clr;
            cfg_timeout = tbl[i].cfg;
            step();
            chk($sformatf("tbl%0d.time_out", i), 32'(to0), 32'(tbl[i].to));
            chk($sformatf("tbl%0d.expired", i), 32'(ex0), 32'(tbl[i].ex));
            chk($sformatf("tbl%0d.busy", i), 32'(bz0), 32'(tbl[i].bz));
        end

        // One-shot: cfg=5 on channel 0, single pulse five edges after arm.
        stop = 4'hf; clr = 4'hf; step();
        cfg_timeout = 5; arm = 4'b0001; step();
        arm_edge = e; pulses = 0; first_edge = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (to0[0]) begin pulses++; if (first_edge < 0) first_edge = e - arm_edge; end
            if (e - arm_edge == 6) chk("oneshot.any_expired", 32'(any0), 32'd1);
        end
        chk("oneshot.pulses", 32'(pulses), 32'd1);
        chk("oneshot.latency", 32'(first_edge), 32'd5);

        // Kick: cfg=8 on channel 1, kicks at +6 and +12, expiry at +20, then kick in DONE.
        stop = 4'hf; clr = 4'hf; step();
        cfg_timeout = 8; arm = 4'b0010; step();
        arm_edge = e; first_edge = -1; pulses = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 6 || i == 12 || i == 25) kick = 4'b0010;
            step();
            if (to0[1]) begin pulses++; if (first_edge < 0) first_edge = e - arm_edge; end
        end
        chk("kick.latency", 32'(first_edge), 32'd20);
        chk("kick.pulses", 32'(pulses), 32'd1);

        // Periodic: cfg=3 on channel 2 of the reload instance, stop on the fourth expiry edge.
        stop = 4'hf; clr = 4'hf; step();
        cfg_timeout = 3; arm = 4'b0100; step();
        pulses = 0;
        for (int i = 1; i <= 11; i++) begin
            step();
            if (to1[2]) pulses++;
        end
        chk("periodic.pulses", 32'(pulses), 32'd3);
        stop = 4'b0100; step();
        chk("periodic.stop_pulse", 32'(to1[2]), 32'd0);
        chk("periodic.stop_busy", 32'(bz1[2]), 32'd0);

        // Readback of channel 3 during a count of 100, then reset at cnt=40.
        stop = 4'hf; clr = 4'hf; step();
        rd_sel = 3; cfg_timeout = 100; arm = 4'b1000; step();
        repeat (60) step();
        chk("readback.cnt40", rd0, 32'd41);
        @(negedge aclk);
        areset = 1'b1;
        #1;
        model_reset();
        chk("reset.busy", 32'({bz0, bz1}), 32'd0);
        chk("reset.rd_cnt", rd0 | rd1, 32'd0);
        chk("reset.any_expired", 32'({any0, any1}), 32'd0);
        chk("reset.time_out", 32'({to0, to1, ex0, ex1}), 32'd0);
        @(negedge aclk);
        areset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (to0 != 0 || to1 != 0) pulses++;
        end
        chk("reset.no_pulse", 32'(pulses), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 4; c++) begin
                arm[c]  = ($urandom_range(0, 15) == 0);
                kick[c] = ($urandom_range(0, 9) == 0);
                stop[c] = ($urandom_range(0, 39) == 0);
                clr[c]  = ($urandom_range(0, 7) == 0);
            end
            cfg_timeout = $urandom_range(0, 10);
            rd_sel = 3'($urandom_range(0, 7));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
